slot_payout_ctrl: RTL and testbench
===================================

# slot_payout_ctrl

Credit and spin controller for the casino slot machine. Sits directly downstream of the three-reel RNG stage. It accepts coins, debits a bet per spin, and issues the one-cycle `button_press` that advances the RNG. It then captures the three 3-bit reel values on the following cycle, scores them, and credits the payout with saturation.

## Interface
- `CREDIT_W`, default 8: width of the credit counter and payout values.
- `BET`, default 1: credits debited per accepted spin.
- `PAY_PAIR`, default 2: payout when exactly two reels match.
- `PAY_TRIPLE`, default 10: payout when three reels match on a value other than 7.
- `PAY_JACKPOT`, default 50: payout for 7-7-7.

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge clears all state.
- `coin_in`  in  1  one-cycle pulse; adds 1 credit.
- `spin_req`  in  1  one-cycle pulse; requests a spin.
- `cash_out`  in  1  one-cycle pulse; pays out all credits.
- `rng1`, `rng2`, `rng3`  in  3 each  registered reel values from the RNG stage.
- `button_press`  out  1  advance strobe to the RNG stage.
- `credits`  out  CREDIT_W  current credit balance.
- `reel1`, `reel2`, `reel3`  out  3 each  captured reel values of the last spin.
- `last_payout`  out  CREDIT_W  payout of the last scored spin.
- `win`  out  1  level; last spin paid > 0.
- `jackpot`  out  1  level; last spin was 7-7-7.
- `busy`  out  1  high in any state other than IDLE.
- `no_credit`  out  1  one-cycle pulse; spin rejected for insufficient credit.
- `cash_amt`  out  CREDIT_W  amount paid at last cash-out.
- `cash_done`  out  1  one-cycle pulse; cash-out completed.

## Operation
- FSM states: IDLE, SPIN, CAPTURE, EVAL.
- **IDLE**
  - `spin_req` with `credits >= BET`: debit BET, go to SPIN.
  - `spin_req` with `credits < BET`: pulse `no_credit`, stay in IDLE.
  - `cash_out` without `spin_req`: `cash_amt <= credits`, `credits <= 0`, pulse `cash_done`.
  - `spin_req` and `cash_out` in the same cycle: spin wins; `cash_out` is dropped.
- **SPIN**: `button_press` = 1 for exactly this cycle. Go to CAPTURE.
- **CAPTURE**: RNG outputs are now updated. Latch `rng1..3` into `reel1..3`. Go to EVAL.
- **EVAL**: compute payout from `reel1..3`, in priority order:
  - all three equal 7: PAY_JACKPOT;
  - all three equal: PAY_TRIPLE;
  - any two equal: PAY_PAIR;
  - otherwise 0.
- **EVAL writes**: `last_payout`, `win = (payout != 0)`, `jackpot`, and `credits += payout`. Go to IDLE.
- **`win` / `jackpot`**: hold their value until the next EVAL. They are cleared on entry to SPIN.
- **`coin_in`**: accepted in every state.
- **Simultaneous credit updates**: net = coin + payout − debit, computed in CREDIT_W+2 bits, then clamped to [0, 2^CREDIT_W−1].
  - A coin in the same cycle as an accepted spin yields net +1−BET.
  - The affordability check uses pre-coin `credits`.
- **Busy inputs**: `spin_req` and `cash_out` received while `busy` are ignored (no queuing, no `no_credit`).
- **Reset values**: all outputs 0 (`credits`, `reels`, `last_payout`, `cash_amt`, `win`, `jackpot`, `busy`, `button_press`, pulses); state IDLE.
- **Reset mid-spin**: abort to IDLE with no payout. The debited bet is lost because credits clear.

## Timing
- Spin request accepted at edge T0 (IDLE→SPIN, debit visible after T0).
- `button_press` is high during cycle T0..T1.
- RNG registers update at T1; reels are latched at T2.
- `credits`, `win`, `jackpot`, `last_payout` are valid after T3; `busy` falls after T3.
- Spin-to-result latency: 3 cycles. Minimum spacing between accepted spins: 4 cycles (next `spin_req` sampled at T3 is in IDLE... no: T3 is the EVAL edge, so earliest accepted next request is at T4).
- `no_credit` and `cash_done` assert the cycle after the request edge, for one cycle.
- `button_press` is never asserted outside SPIN; exactly one pulse per accepted spin.

## Test plan
- **Reset then spin with no credit**: reset low 2 cycles, then `spin_req` → `credits`=0, `no_credit` pulses once, `button_press` stays 0, `busy` stays 0.
- **Losing spin**: 3 `coin_in` pulses, then `spin_req`; bench drives rng=2,5,6 at CAPTURE → `button_press` exactly 1 cycle; reels=2,5,6; `last_payout`=0; `win`=0; `credits`=2 at T3.
- **Pair, triple and jackpot**:
  - rng=4,4,1 → `credits` +2, `win`=1;
  - rng=3,3,3 → +10, `jackpot`=0;
  - rng=7,7,7 → +50, `jackpot`=1;
  - each result held until the next SPIN.
- **Saturation and simultaneity**:
  - `credits`=250, jackpot with `coin_in` during EVAL → `credits`=255;
  - `credits`=255 plus `coin_in` → stays 255;
  - `coin_in` together with accepted `spin_req` at `credits`=1 → `credits`=1.
- **Cash-out**:
  - `credits`=17, `cash_out` in IDLE → `cash_amt`=17, `credits`=0, `cash_done` 1 cycle;
  - `cash_out` during SPIN → ignored;
  - `spin_req` and `cash_out` together at `credits`=5 → spin taken, `credits`=4, no `cash_done`.
- **Reset mid-spin**: assert reset in CAPTURE → next cycle state IDLE, all outputs 0, no payout applied afterwards; `spin_req` while busy → no second `button_press`.

Source files
------------

// File: rtl/slot_payout_ctrl.sv
// Slot machine credit/spin controller: takes coins, debits a bet per spin, strobes the
// RNG, captures and scores the reels, and credits the payout with saturation.
module slot_payout_ctrl #(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned BET         = 1,
  parameter int unsigned PAY_PAIR    = 2,
  parameter int unsigned PAY_TRIPLE  = 10,
  parameter int unsigned PAY_JACKPOT = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_in,
  input  logic                spin_req,
  input  logic                cash_out,
  input  logic [2:0]          rng1,
  input  logic [2:0]          rng2,
  input  logic [2:0]          rng3,
  output logic                button_press,
  output logic [CREDIT_W-1:0] credits,
  output logic [2:0]          reel1,
  output logic [2:0]          reel2,
  output logic [2:0]          reel3,
  output logic [CREDIT_W-1:0] last_payout,
  output logic                win,
  output logic                jackpot,
  output logic                busy,
  output logic                no_credit,
  output logic [CREDIT_W-1:0] cash_amt,
  output logic                cash_done
);

  localparam int unsigned SUM_W = CREDIT_W + 2;
  localparam logic [SUM_W-1:0] MAX_CREDIT = {2'b00, {CREDIT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, SPIN, CAPTURE, EVAL} state_t;

  state_t state, state_next;

  logic                button_press_next;
  logic [CREDIT_W-1:0] credits_next;
  logic [2:0]          reel1_next, reel2_next, reel3_next;
  logic [CREDIT_W-1:0] last_payout_next;
  logic                win_next, jackpot_next, busy_next;
  logic                no_credit_next, cash_done_next;
  logic [CREDIT_W-1:0] cash_amt_next;

  logic                debit, clear_credits;
  logic [CREDIT_W-1:0] payout;
  logic                is_triple, is_jackpot, is_pair;
  logic [CREDIT_W-1:0] score;
  logic [SUM_W-1:0]    sum;

  // Reel scoring, priority jackpot > triple > pair
  always_comb begin
    is_triple  = (reel1 == reel2) && (reel2 == reel3);
    is_jackpot = is_triple && (reel1 == 3'd7);
    is_pair    = (reel1 == reel2) || (reel2 == reel3) || (reel1 == reel3);
    if (is_jackpot)     score = CREDIT_W'(PAY_JACKPOT);
    else if (is_triple) score = CREDIT_W'(PAY_TRIPLE);
    else if (is_pair)   score = CREDIT_W'(PAY_PAIR);
    else                score = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next        = state;
    button_press_next = 1'b0;
    no_credit_next    = 1'b0;
    cash_done_next    = 1'b0;
    cash_amt_next     = cash_amt;
    reel1_next        = reel1;
    reel2_next        = reel2;
    reel3_next        = reel3;
    last_payout_next  = last_payout;
    win_next          = win;
    jackpot_next      = jackpot;
    debit             = 1'b0;
    clear_credits     = 1'b0;
    payout            = '0;

    case (state)
      IDLE: begin
        // Spin has priority over cash-out; affordability uses pre-coin balance
        if (spin_req) begin
          if ({2'b00, credits} >= SUM_W'(BET)) begin
            debit             = 1'b1;
            button_press_next = 1'b1;
            win_next          = 1'b0;
            jackpot_next      = 1'b0;
            state_next        = SPIN;
          end else begin
            no_credit_next = 1'b1;
          end
        end else if (cash_out) begin
          cash_amt_next  = credits;
          clear_credits  = 1'b1;
          cash_done_next = 1'b1;
        end
      end
      SPIN: state_next = CAPTURE;
      CAPTURE: begin
        reel1_next = rng1;
        reel2_next = rng2;
        reel3_next = rng3;
        state_next = EVAL;
      end
      EVAL: begin
        payout           = score;
        last_payout_next = score;
        win_next         = (score != '0);
        jackpot_next     = is_jackpot;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Net credit change in two extra bits, then clamped to the counter range
    sum = (clear_credits ? '0 : {2'b00, credits})
        + SUM_W'(coin_in)
        + {2'b00, payout}
        - (debit ? SUM_W'(BET) : '0);
    if (sum[SUM_W-1])          credits_next = '0;
    else if (sum > MAX_CREDIT) credits_next = MAX_CREDIT[CREDIT_W-1:0];
    else                       credits_next = sum[CREDIT_W-1:0];

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      button_press <= 1'b0;
      credits      <= '0;
      reel1        <= '0;
      reel2        <= '0;
      reel3        <= '0;
      last_payout  <= '0;
      win          <= 1'b0;
      jackpot      <= 1'b0;
      busy         <= 1'b0;
      no_credit    <= 1'b0;
      cash_amt     <= '0;
      cash_done    <= 1'b0;
    end else begin
      button_press <= button_press_next;
      credits      <= credits_next;
      reel1        <= reel1_next;
      reel2        <= reel2_next;
      reel3        <= reel3_next;
      last_payout  <= last_payout_next;
      win          <= win_next;
      jackpot      <= jackpot_next;
      busy         <= busy_next;
      no_credit    <= no_credit_next;
      cash_amt     <= cash_amt_next;
      cash_done    <= cash_done_next;
    end
  end

endmodule

// File: tb/tb_slot_payout_ctrl.sv
// Directed bench for slot_payout_ctrl with hand-computed expected values.
module tb_slot_payout_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_in, spin_req, cash_out;
  logic [2:0] rng1, rng2, rng3;
  logic       button_press;
  logic [7:0] credits;
  logic [2:0] reel1, reel2, reel3;
  logic [7:0] last_payout;
  logic       win, jackpot, busy, no_credit;
  logic [7:0] cash_amt;
  logic       cash_done;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_count = 0;
  int bp_base;

  slot_payout_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .coin_in      (coin_in),
    .spin_req     (spin_req),
    .cash_out     (cash_out),
    .rng1         (rng1),
    .rng2         (rng2),
    .rng3         (rng3),
    .button_press (button_press),
    .credits      (credits),
    .reel1        (reel1),
    .reel2        (reel2),
    .reel3        (reel3),
    .last_payout  (last_payout),
    .win          (win),
    .jackpot      (jackpot),
    .busy         (busy),
    .no_credit    (no_credit),
    .cash_amt     (cash_amt),
    .cash_done    (cash_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (button_press) bp_count <= bp_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) begin
      coin_in = 1'b1;
      tick();
      coin_in = 1'b0;
    end
  endtask

  // Full spin: returns right after the EVAL edge (T3)
  task automatic spin(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3,
                      input logic coin_at_eval);
    spin_req = 1'b1;
    tick();
    spin_req = 1'b0;
    check("press_in_spin", button_press, 1);
    check("busy_in_spin", busy, 1);
    check("win_clr_spin", win, 0);
    check("jack_clr_spin", jackpot, 0);
    tick();
    check("press_off_capture", button_press, 0);
    rng1 = r1; rng2 = r2; rng3 = r3;
    tick();
    coin_in = coin_at_eval;
    tick();
    coin_in = 1'b0;
    check("busy_after_eval", busy, 0);
  endtask

  initial begin
    reset = 1'b0; coin_in = 1'b0; spin_req = 1'b0; cash_out = 1'b0;
    rng1 = '0; rng2 = '0; rng3 = '0;
    tick(); tick();
    check("rst_credits", credits, 0);
    check("rst_busy", busy, 0);
    check("rst_press", button_press, 0);
    check("rst_win", win, 0);
    reset = 1'b1;

    // No credit
    spin_req = 1'b1;
    tick();
    spin_req = 1'b0;
    check("nocred_pulse", no_credit, 1);
    check("nocred_busy", busy, 0);
    check("nocred_press", button_press, 0);
    tick();
    check("nocred_one_cycle", no_credit, 0);
    check("nocred_credits", credits, 0);

    // Losing spin
    coins(3);
    check("coins3", credits, 3);
    bp_base = bp_count;
    spin(3'd2, 3'd5, 3'd6, 1'b0);
    check("lose_press_count", bp_count - bp_base, 1);
    check("lose_reels", {reel1, reel2, reel3}, {3'd2, 3'd5, 3'd6});
    check("lose_payout", last_payout, 0);
    check("lose_win", win, 0);
    check("lose_credits", credits, 2);

    // Pair, triple, jackpot
    spin(3'd4, 3'd4, 3'd1, 1'b0);
    check("pair_credits", credits, 3);
    check("pair_win", win, 1);
    check("pair_payout", last_payout, 2);
    spin(3'd3, 3'd3, 3'd3, 1'b0);
    check("triple_credits", credits, 12);
    check("triple_jack", jackpot, 0);
    check("triple_win", win, 1);
    spin(3'd7, 3'd7, 3'd7, 1'b0);
    check("jack_credits", credits, 61);
    check("jack_flag", jackpot, 1);
    check("jack_payout", last_payout, 50);
    tick(); tick(); tick();
    check("jack_held", jackpot, 1);
    check("win_held", win, 1);
    spin(3'd1, 3'd2, 3'd3, 1'b0);
    check("after_lose_credits", credits, 60);

    // Saturation
    coins(190);
    check("credits250", credits, 250);
    spin(3'd7, 3'd7, 3'd7, 1'b1);
    check("sat_jackpot", credits, 255);
    coins(1);
    check("sat_coin", credits, 255);

    // Cash-out
    cash_out = 1'b1;
    tick();
    cash_out = 1'b0;
    check("cash255_amt", cash_amt, 255);
    check("cash255_credits", credits, 0);
    coins(17);
    cash_out = 1'b1;
    tick();
    cash_out = 1'b0;
    check("cash17_amt", cash_amt, 17);
    check("cash17_credits", credits, 0);
    check("cash17_done", cash_done, 1);
    tick();
    check("cash17_done_1cyc", cash_done, 0);

    // Coin with accepted spin at 1 credit; cash-out and spin_req while busy ignored
    coins(1);
    bp_base = bp_count;
    spin_req = 1'b1; coin_in = 1'b1;
    tick();
    spin_req = 1'b0; coin_in = 1'b0;
    check("coin_spin_credits", credits, 1);
    cash_out = 1'b1;
    tick();
    cash_out = 1'b0;
    check("busy_cash_done", cash_done, 0);
    spin_req = 1'b1; rng1 = 3'd0; rng2 = 3'd1; rng3 = 3'd2;
    tick();
    spin_req = 1'b0;
    tick();
    check("busy_cash_credits", credits, 1);
    check("busy_cash_amt", cash_amt, 17);
    tick(); tick();
    check("busy_spin_press_count", bp_count - bp_base, 1);
    check("busy_spin_idle", busy, 0);

    // spin + cash_out together at 5 credits
    coins(4);
    cash_out = 1'b1;
    spin(3'd0, 3'd1, 3'd2, 1'b0);
    cash_out = 1'b0;
    check("spin_cash_credits", credits, 4);
    check("spin_cash_amt", cash_amt, 17);

    // Reset mid-spin (in CAPTURE)
    spin_req = 1'b1;
    tick();
    spin_req = 1'b0;
    check("mid_debit", credits, 3);
    tick();
    reset = 1'b0; rng1 = 3'd7; rng2 = 3'd7; rng3 = 3'd7;
    tick();
    reset = 1'b1;
    check("mid_credits", credits, 0);
    check("mid_busy", busy, 0);
    check("mid_reels", {reel1, reel2, reel3}, 0);
    check("mid_cash_amt", cash_amt, 0);
    check("mid_payout", last_payout, 0);
    tick(); tick(); tick();
    check("mid_no_payout", credits, 0);
    check("mid_still_idle", busy, 0);
    check("mid_win", win, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
